nf_uart_loader: RTL and testbench

Boot loader that receives a program image over a UART RX line and writes it word-by-word into the instruction memory write port. It sits directly upstream of the instruction memory and holds the CPU in reset until the image is complete. It then releases the CPU, which begins fetching from address 0.

---
 rtl/nf_loader_pkg.sv | 23 ++
 rtl/nf_uart_rx.sv | 144 ++++++++++++++
 rtl/nf_uart_loader.sv | 197 +++++++++++++++++++
 tb/tb_nf_uart_loader.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/nf_loader_pkg.sv
// Shared types and constants for the UART boot loader: image FSM states,
// receiver states and the image framing constants.
package nf_loader_pkg;

    typedef enum logic [2:0] {
        ST_HDR_LO = 3'd0,
        ST_HDR_HI = 3'd1,
        ST_WORD   = 3'd2,
        ST_DONE   = 3'd3,
        ST_ERR    = 3'd4
    } load_state_e;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_e;

    localparam int unsigned HDR_BYTES  = 2;
    localparam int unsigned WORD_BYTES = 4;

endpackage

// File: rtl/nf_uart_rx.sv
// 8N1 UART receiver: synchronizer, start-bit glitch filter, mid-bit sampling
// and one-cycle byte / framing-error strobes.
module nf_uart_rx
    import nf_loader_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        rx,
    input  logic [15:0] baud_div,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    output logic        rx_ferr,
    output logic        rx_busy
);

    rx_state_e   state_r;
    rx_state_e   state_s;
    logic        rx_meta_r;
    logic        rx_sync_r;
    logic        rx_last_r;
    logic [15:0] div_r;
    logic [15:0] div_s;
    logic [15:0] cnt_r;
    logic [15:0] cnt_s;
    logic [2:0]  bit_r;
    logic [2:0]  bit_s;
    logic [7:0]  shift_r;
    logic [7:0]  shift_s;
    logic        valid_s;
    logic        ferr_s;
    logic [7:0]  data_r;
    logic        valid_r;
    logic        ferr_r;
    logic        busy_r;

    // Two-flop synchronizer plus a history flop for falling-edge detection.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rx_meta_r <= 1'b1;
            rx_sync_r <= 1'b1;
            rx_last_r <= 1'b1;
        end else begin
            rx_meta_r <= rx;
            rx_sync_r <= rx_meta_r;
            rx_last_r <= rx_sync_r;
        end
    end

    // Receiver next-state: start is re-checked half a bit in, then every bit is
    // sampled baud_div cycles after the previous sample.
    always_comb begin
        state_s = state_r;
        div_s   = div_r;
        cnt_s   = cnt_r;
        bit_s   = bit_r;
        shift_s = shift_r;
        valid_s = 1'b0;
        ferr_s  = 1'b0;
        case (state_r)
            RX_IDLE: begin
                if (rx_last_r && !rx_sync_r) begin
                    state_s = RX_START;
                    div_s   = baud_div;
                    cnt_s   = 16'd0;
                end else begin
                    state_s = RX_IDLE;
                end
            end
            RX_START: begin
                if (cnt_r == ((div_r >> 1) - 16'd1)) begin
                    cnt_s = 16'd0;
                    bit_s = 3'd0;
                    if (rx_sync_r) begin
                        state_s = RX_IDLE;
                    end else begin
                        state_s = RX_DATA;
                    end
                end else begin
                    cnt_s = cnt_r + 16'd1;
                end
            end
            RX_DATA: begin
                if (cnt_r == (div_r - 16'd1)) begin
                    cnt_s   = 16'd0;
                    shift_s = {rx_sync_r, shift_r[7:1]};
                    if (bit_r == 3'd7) begin
                        state_s = RX_STOP;
                    end else begin
                        bit_s = bit_r + 3'd1;
                    end
                end else begin
                    cnt_s = cnt_r + 16'd1;
                end
            end
            RX_STOP: begin
                if (cnt_r == (div_r - 16'd1)) begin
                    cnt_s   = 16'd0;
                    state_s = RX_IDLE;
                    if (rx_sync_r) begin
                        valid_s = 1'b1;
                    end else begin
                        ferr_s = 1'b1;
                    end
                end else begin
                    cnt_s = cnt_r + 16'd1;
                end
            end
            default: begin
                state_s = RX_IDLE;
            end
        endcase
    end

    // Receiver state and registered strobes.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r <= RX_IDLE;
            div_r   <= 16'd0;
            cnt_r   <= 16'd0;
            bit_r   <= 3'd0;
            shift_r <= 8'd0;
            data_r  <= 8'd0;
            valid_r <= 1'b0;
            ferr_r  <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            div_r   <= div_s;
            cnt_r   <= cnt_s;
            bit_r   <= bit_s;
            shift_r <= shift_s;
            data_r  <= valid_s ? shift_r : data_r;
            valid_r <= valid_s;
            ferr_r  <= ferr_s;
            busy_r  <= (state_s != RX_IDLE);
        end
    end

    assign rx_data  = data_r;
    assign rx_valid = valid_r;
    assign rx_ferr  = ferr_r;
    assign rx_busy  = busy_r;

endmodule

// File: rtl/nf_uart_loader.sv
// Boot loader: parses a length-prefixed image from the UART and writes it into
// instruction memory, holding the CPU in reset until the image is complete.
module nf_uart_loader
    import nf_loader_pkg::*;
#(
    parameter int depth = 64
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        rx,
    input  logic [15:0] baud_div,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wd,
    output logic        cpu_resetn,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam int          IW      = $clog2(depth + 1);
    localparam logic [15:0] DEPTH_W = 16'(depth);
    localparam logic [1:0]  LAST_B  = 2'(WORD_BYTES - 1);

    logic [7:0]  rx_data_s;
    logic        rx_valid_s;
    logic        rx_ferr_s;
    logic        rx_busy_s;

    load_state_e state_r;
    load_state_e state_s;
    logic [15:0] n_r;
    logic [15:0] n_s;
    logic [15:0] hdr_s;
    logic [IW-1:0] idx_r;
    logic [IW-1:0] idx_s;
    logic [IW-1:0] idx_inc_s;
    logic [1:0]  bcnt_r;
    logic [1:0]  bcnt_s;
    logic [23:0] word_r;
    logic [23:0] word_s;
    logic        mem_we_s;
    logic [31:0] mem_addr_s;
    logic [31:0] mem_wd_s;
    logic        busy_s;
    logic        mem_we_r;
    logic [31:0] mem_addr_r;
    logic [31:0] mem_wd_r;
    logic        cpu_resetn_r;
    logic        busy_r;
    logic        done_r;
    logic        err_r;

    nf_uart_rx u_rx (
        .clk      (clk),
        .resetn   (resetn),
        .rx       (rx),
        .baud_div (baud_div),
        .rx_data  (rx_data_s),
        .rx_valid (rx_valid_s),
        .rx_ferr  (rx_ferr_s),
        .rx_busy  (rx_busy_s)
    );

    // Image FSM: header bytes, then little-endian words; terminal states ignore rx.
    always_comb begin
        state_s    = state_r;
        n_s        = n_r;
        idx_s      = idx_r;
        bcnt_s     = bcnt_r;
        word_s     = word_r;
        mem_we_s   = 1'b0;
        mem_addr_s = mem_addr_r;
        mem_wd_s   = mem_wd_r;
        hdr_s      = {rx_data_s, n_r[7:0]};
        idx_inc_s  = idx_r + IW'(1);
        case (state_r)
            ST_HDR_LO: begin
                if (rx_ferr_s) begin
                    state_s = ST_ERR;
                end else if (rx_valid_s) begin
                    n_s     = {8'd0, rx_data_s};
                    state_s = ST_HDR_HI;
                end else begin
                    state_s = ST_HDR_LO;
                end
            end
            ST_HDR_HI: begin
                if (rx_ferr_s) begin
                    state_s = ST_ERR;
                end else if (rx_valid_s) begin
                    n_s = hdr_s;
                    if (hdr_s > DEPTH_W) begin
                        state_s = ST_ERR;
                    end else if (hdr_s == 16'd0) begin
                        state_s = ST_DONE;
                    end else begin
                        state_s = ST_WORD;
                        idx_s   = '0;
                        bcnt_s  = 2'd0;
                    end
                end else begin
                    state_s = ST_HDR_HI;
                end
            end
            ST_WORD: begin
                if (rx_ferr_s) begin
                    state_s = ST_ERR;
                end else if (rx_valid_s) begin
                    bcnt_s = bcnt_r + 2'd1;
                    case (bcnt_r)
                        2'd0:    word_s[7:0]   = rx_data_s;
                        2'd1:    word_s[15:8]  = rx_data_s;
                        2'd2:    word_s[23:16] = rx_data_s;
                        default: word_s        = word_r;
                    endcase
                    if (bcnt_r == LAST_B) begin
                        mem_we_s   = 1'b1;
                        mem_addr_s = {{(32 - IW - 2){1'b0}}, idx_r, 2'b00};
                        mem_wd_s   = {rx_data_s, word_r};
                        idx_s      = idx_inc_s;
                        if (16'(idx_inc_s) == n_r) begin
                            state_s = ST_DONE;
                        end else begin
                            state_s = ST_WORD;
                        end
                    end else begin
                        state_s = ST_WORD;
                    end
                end else begin
                    state_s = ST_WORD;
                end
            end
            ST_DONE: begin
                state_s = ST_DONE;
            end
            ST_ERR: begin
                state_s = ST_ERR;
            end
            default: begin
                state_s = ST_ERR;
            end
        endcase

        busy_s = (state_r == ST_HDR_HI)
              || ((state_r == ST_WORD) && (bcnt_r != 2'd0))
              || (rx_busy_s && (state_r != ST_DONE) && (state_r != ST_ERR));
    end

    // FSM state and datapath registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r <= ST_HDR_LO;
            n_r     <= 16'd0;
            idx_r   <= '0;
            bcnt_r  <= 2'd0;
            word_r  <= 24'd0;
        end else begin
            state_r <= state_s;
            n_r     <= n_s;
            idx_r   <= idx_s;
            bcnt_r  <= bcnt_s;
            word_r  <= word_s;
        end
    end

    // Registered outputs; status flags follow the state one cycle later so that
    // done trails the final write strobe.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mem_we_r     <= 1'b0;
            mem_addr_r   <= 32'd0;
            mem_wd_r     <= 32'd0;
            cpu_resetn_r <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            err_r        <= 1'b0;
        end else begin
            mem_we_r     <= mem_we_s;
            mem_addr_r   <= mem_addr_s;
            mem_wd_r     <= mem_wd_s;
            cpu_resetn_r <= (state_r == ST_DONE);
            busy_r       <= busy_s;
            done_r       <= (state_r == ST_DONE);
            err_r        <= (state_r == ST_ERR);
        end
    end

    assign mem_we     = mem_we_r;
    assign mem_addr   = mem_addr_r;
    assign mem_wd     = mem_wd_r;
    assign cpu_resetn = cpu_resetn_r;
    assign busy       = busy_r;
    assign done       = done_r;
    assign err        = err_r;

endmodule

// File: tb/tb_nf_uart_loader.sv
// Directed bench for nf_uart_loader: drives UART frames at baud_div=4 and
// checks write strobes and status flags against hand-computed values.
module tb_nf_uart_loader;

    localparam int BAUD = 4;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        rx = 1'b1;
    logic [15:0] baud_div = 16'd4;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wd;
    logic        cpu_resetn;
    logic        busy;
    logic        done;
    logic        err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int we_n = 0;
    int last_we_cyc = 0;
    int done_rise_cyc = 0;
    int base = 0;
    logic done_q = 1'b0;
    logic [31:0] we_addr [64];
    logic [31:0] we_wd [64];

    nf_uart_loader #(.depth(64)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .rx         (rx),
        .baud_div   (baud_div),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wd     (mem_wd),
        .cpu_resetn (cpu_resetn),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Write-port and done monitor, sampled mid-cycle.
    always @(negedge clk) begin
        done_q <= done;
        if (done === 1'b1 && done_q === 1'b0) done_rise_cyc <= cyc;
        if (mem_we === 1'b1) begin
            if (we_n < 64) begin
                we_addr[we_n] <= mem_addr;
                we_wd[we_n]   <= mem_wd;
            end
            we_n        <= we_n + 1;
            last_we_cyc <= cyc;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_we"},   {31'd0, mem_we},     32'd0);
        check({tag, "_addr"}, mem_addr,            32'd0);
        check({tag, "_wd"},   mem_wd,              32'd0);
        check({tag, "_cpu"},  {31'd0, cpu_resetn}, 32'd0);
        check({tag, "_busy"}, {31'd0, busy},       32'd0);
        check({tag, "_done"}, {31'd0, done},       32'd0);
        check({tag, "_err"},  {31'd0, err},        32'd0);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        repeat (BAUD) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (BAUD) @(negedge clk);
        end
        rx = stop;
        repeat (BAUD) @(negedge clk);
        rx = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic send_hdr(input logic [15:0] n);
        send_byte(n[7:0], 1'b1);
        send_byte(n[15:8], 1'b1);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], 1'b1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        resetn = 1'b0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        // Reset state
        resetn = 1'b0;
        rx = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        resetn = 1'b1;
        repeat (2) @(negedge clk);

        // Two-word image
        base = we_n;
        send_hdr(16'h0002);
        send_word(32'h00500093);
        send_word(32'h00108113);
        repeat (8) @(negedge clk);
        check("t1_we_count", 32'(we_n - base), 32'd2);
        check("t1_addr0", we_addr[base], 32'h0);
        check("t1_wd0",   we_wd[base],   32'h00500093);
        check("t1_addr1", we_addr[base + 1], 32'h4);
        check("t1_wd1",   we_wd[base + 1],   32'h00108113);
        check("t1_done", {31'd0, done}, 32'd1);
        check("t1_cpu",  {31'd0, cpu_resetn}, 32'd1);
        check("t1_err",  {31'd0, err}, 32'd0);
        check("t1_done_lat", 32'(done_rise_cyc), 32'(last_we_cyc + 1));

        // Empty image, then trailing traffic ignored
        do_reset();
        base = we_n;
        send_hdr(16'h0000);
        repeat (6) @(negedge clk);
        check("t2_done", {31'd0, done}, 32'd1);
        check("t2_cpu",  {31'd0, cpu_resetn}, 32'd1);
        send_byte(8'h55, 1'b1);
        send_byte(8'hAA, 1'b1);
        repeat (6) @(negedge clk);
        check("t2_we_count", 32'(we_n - base), 32'd0);
        check("t2_done_hold", {31'd0, done}, 32'd1);
        check("t2_err", {31'd0, err}, 32'd0);
        check("t2_busy", {31'd0, busy}, 32'd0);

        // Oversize header (65 > depth)
        do_reset();
        base = we_n;
        send_hdr(16'h0041);
        repeat (6) @(negedge clk);
        check("t3_err", {31'd0, err}, 32'd1);
        check("t3_cpu", {31'd0, cpu_resetn}, 32'd0);
        check("t3_done", {31'd0, done}, 32'd0);
        check("t3_we_count", 32'(we_n - base), 32'd0);

        // Oversize only in the high byte: full 16-bit compare
        do_reset();
        send_hdr(16'h0100);
        repeat (6) @(negedge clk);
        check("t3_hi_err", {31'd0, err}, 32'd1);

        // N == depth is accepted
        do_reset();
        send_hdr(16'h0040);
        repeat (6) @(negedge clk);
        check("t3_eq_err", {31'd0, err}, 32'd0);
        check("t3_eq_busy", {31'd0, busy}, 32'd0);

        // Framing error on third byte of a word
        do_reset();
        base = we_n;
        send_hdr(16'h0001);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        check("t4_busy_mid", {31'd0, busy}, 32'd1);
        send_byte(8'h33, 1'b0);
        repeat (6) @(negedge clk);
        check("t4_err", {31'd0, err}, 32'd1);
        check("t4_we_count", 32'(we_n - base), 32'd0);
        check("t4_busy", {31'd0, busy}, 32'd0);
        check("t4_cpu", {31'd0, cpu_resetn}, 32'd0);

        // One-cycle glitch while idle
        do_reset();
        base = we_n;
        rx = 1'b0;
        @(negedge clk);
        rx = 1'b1;
        repeat (20) @(negedge clk);
        check("t5_busy", {31'd0, busy}, 32'd0);
        check("t5_err", {31'd0, err}, 32'd0);
        check("t5_done", {31'd0, done}, 32'd0);
        send_hdr(16'h0001);
        send_word(32'hDEADBEEF);
        repeat (8) @(negedge clk);
        check("t5_we_count", 32'(we_n - base), 32'd1);
        check("t5_addr0", we_addr[base], 32'h0);
        check("t5_wd0", we_wd[base], 32'hDEADBEEF);
        check("t5_done_after", {31'd0, done}, 32'd1);

        // Reset after 2 of 4 words, then a fresh image
        do_reset();
        base = we_n;
        send_hdr(16'h0004);
        send_word(32'h11223344);
        send_word(32'hA5A5C3C3);
        repeat (4) @(negedge clk);
        check("t6_pre_count", 32'(we_n - base), 32'd2);
        check("t6_pre_addr", mem_addr, 32'h4);
        resetn = 1'b0;
        #1;
        check_reset_outputs("t6_rst");
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        repeat (2) @(negedge clk);
        base = we_n;
        send_hdr(16'h0002);
        send_word(32'hCAFEF00D);
        send_word(32'h01020304);
        repeat (8) @(negedge clk);
        check("t6_we_count", 32'(we_n - base), 32'd2);
        check("t6_addr0", we_addr[base], 32'h0);
        check("t6_wd0", we_wd[base], 32'hCAFEF00D);
        check("t6_addr1", we_addr[base + 1], 32'h4);
        check("t6_wd1", we_wd[base + 1], 32'h01020304);
        check("t6_done", {31'd0, done}, 32'd1);
        check("t6_cpu", {31'd0, cpu_resetn}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
